// File: rtl/proj_group_mux_seq.sv
// Sequenced project multiplexer: drains the old slot, holds the new slot in reset, then connects it.
// Optional macro PROJ_MUX_OUT_REG_EN registers uo_out (one extra cycle of output latency).
`timescale 1ns/1ps
module proj_group_mux_seq #(
   parameter int unsigned N_PROJ     = 16,
   parameter int unsigned SEL_W      = 4,
   parameter int unsigned DW         = 8,
   parameter int unsigned SETTLE_CYC = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic [SEL_W-1:0]     sel_req,
   input  logic                 sel_load,
   input  logic [N_PROJ-1:0]    proj_present,
   input  logic [N_PROJ*DW-1:0] proj_out_flat,
   output logic [DW-1:0]        uo_out,
   output logic [N_PROJ-1:0]    proj_ena,
   output logic [N_PROJ-1:0]    proj_rst,
   output logic [SEL_W-1:0]     sel_cur,
   output logic                 busy,
   output logic                 sel_err
);

   localparam int unsigned CW = $clog2(SETTLE_CYC) + 1;

   typedef enum logic [1:0] {ACTIVE, DRAIN, RSTSEQ, OFF} state_t;

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [SEL_W-1:0] r_sel_cur, w_sel_cur_nxt;
   logic [SEL_W-1:0] r_sel_tgt, w_sel_tgt_nxt;
   logic [SEL_W-1:0] r_pend, w_pend_nxt;
   logic             r_pend_v, w_pend_v_nxt;
   logic             r_sel_err;
   logic             w_req_ok, w_req_store;
   logic [SEL_W-1:0] w_pend_eff;
   logic             w_pend_v_eff;
   logic [DW-1:0]    w_mux, w_uo;

   // Out-of-range indices never match a slot, so they are rejected as well.
   always_comb begin
      w_req_ok = 1'b0;
      for (int unsigned i = 0; i < N_PROJ; i++) begin
         if (sel_req == SEL_W'(i)) w_req_ok = proj_present[i];
      end
   end

   // Anything except an enabled ACTIVE state parks a valid request in pending; a same-cycle load wins.
   assign w_req_store  = sel_load && w_req_ok && !(r_state == ACTIVE && ena);
   assign w_pend_v_eff = w_req_store || r_pend_v;
   assign w_pend_eff   = w_req_store ? sel_req : r_pend;

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_sel_cur_nxt = r_sel_cur;
      w_sel_tgt_nxt = r_sel_tgt;
      w_pend_nxt    = w_pend_eff;
      w_pend_v_nxt  = w_pend_v_eff;
      if (!ena) begin
         w_state_nxt = OFF;
         // An in-flight drain target is kept as pending so it survives the disable.
         if (r_state == DRAIN && !w_pend_v_eff) begin
            w_pend_nxt   = r_sel_tgt;
            w_pend_v_nxt = 1'b1;
         end
      end else begin
         case (r_state)
            ACTIVE: begin
               if (sel_load && w_req_ok && sel_req != r_sel_cur) begin
                  w_state_nxt   = DRAIN;
                  w_sel_tgt_nxt = sel_req;
               end
            end
            DRAIN: begin
               w_state_nxt   = RSTSEQ;
               w_sel_cur_nxt = r_sel_tgt;
               w_cnt_nxt     = CW'(SETTLE_CYC - 1);
            end
            RSTSEQ: begin
               if (r_cnt != '0) begin
                  w_cnt_nxt = r_cnt - CW'(1);
               end else if (w_pend_v_eff && w_pend_eff != r_sel_cur) begin
                  w_state_nxt   = DRAIN;
                  w_sel_tgt_nxt = w_pend_eff;
                  w_pend_v_nxt  = 1'b0;
               end else begin
                  w_state_nxt  = ACTIVE;
                  w_pend_v_nxt = 1'b0;
               end
            end
            OFF: begin
               w_state_nxt = RSTSEQ;
               w_cnt_nxt   = CW'(SETTLE_CYC - 1);
               if (w_pend_v_eff) w_sel_cur_nxt = w_pend_eff;
               w_pend_v_nxt = 1'b0;
            end
            default: w_state_nxt = OFF;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= RSTSEQ;
         r_cnt     <= CW'(SETTLE_CYC - 1);
         r_sel_cur <= '0;
         r_sel_tgt <= '0;
         r_pend    <= '0;
         r_pend_v  <= 1'b0;
         r_sel_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_sel_cur <= w_sel_cur_nxt;
         r_sel_tgt <= w_sel_tgt_nxt;
         r_pend    <= w_pend_nxt;
         r_pend_v  <= w_pend_v_nxt;
         r_sel_err <= sel_load && !w_req_ok;
      end
   end

   // proj_ena is gated by rst so the reset condition shows no enabled slot even though the reset state is RSTSEQ.
   always_comb begin
      w_mux    = '0;
      proj_ena = '0;
      proj_rst = '1;
      for (int unsigned i = 0; i < N_PROJ; i++) begin
         if (r_sel_cur == SEL_W'(i)) begin
            w_mux = proj_out_flat[i*DW +: DW];
            if (r_state == ACTIVE) proj_rst[i] = 1'b0;
            if ((r_state == ACTIVE || r_state == RSTSEQ) && !rst) proj_ena[i] = 1'b1;
         end
      end
   end

   assign w_uo    = (r_state == ACTIVE) ? w_mux : '0;
   assign busy    = (r_state == DRAIN) || (r_state == RSTSEQ);
   assign sel_cur = r_sel_cur;
   assign sel_err = r_sel_err;

`ifdef PROJ_MUX_OUT_REG_EN
   logic [DW-1:0] r_uo;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_uo <= '0;
      else     r_uo <= w_uo;
   end
   assign uo_out = r_uo;
`else
   assign uo_out = w_uo;
`endif

endmodule

// File: tb/tb_proj_group_mux_seq.sv
// Directed, table-driven bench for proj_group_mux_seq (default build, 16 slots plus a 5-slot instance).
`timescale 1ns/1ps
module tb_proj_group_mux_seq;

   logic         clk = 1'b0;
   logic         rst, ena, sel_load;
   logic [3:0]   sel_req;
   logic [15:0]  present;
   logic [127:0] flat;
   logic [7:0]   uo;
   logic [15:0]  pena, prst;
   logic [3:0]   cur;
   logic         busy, err;

   logic         ld5;
   logic [2:0]   req5;
   logic [4:0]   present5;
   logic [39:0]  flat5;
   logic [7:0]   uo5;
   logic [4:0]   pena5, prst5;
   logic [2:0]   cur5;
   logic         busy5, err5;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   proj_group_mux_seq #(.N_PROJ(16), .SEL_W(4), .DW(8), .SETTLE_CYC(4)) dut (
      .clk(clk), .rst(rst), .ena(ena), .sel_req(sel_req), .sel_load(sel_load),
      .proj_present(present), .proj_out_flat(flat), .uo_out(uo), .proj_ena(pena),
      .proj_rst(prst), .sel_cur(cur), .busy(busy), .sel_err(err)
   );

   proj_group_mux_seq #(.N_PROJ(5), .SEL_W(3), .DW(8), .SETTLE_CYC(4)) dut5 (
      .clk(clk), .rst(rst), .ena(ena), .sel_req(req5), .sel_load(ld5),
      .proj_present(present5), .proj_out_flat(flat5), .uo_out(uo5), .proj_ena(pena5),
      .proj_rst(prst5), .sel_cur(cur5), .busy(busy5), .sel_err(err5)
   );

   typedef struct {
      logic        ld;
      logic [3:0]  req;
      logic        en;
      logic        bsy;
      logic [3:0]  cur;
      logic [7:0]  uo;
      logic        err;
      logic [15:0] pe;
      logic [15:0] pr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic ld, logic [3:0] req, logic en, logic bsy, logic [3:0] c,
                               logic [7:0] u, logic e, logic [15:0] pe, logic [15:0] pr);
      vec_t v;
      v.ld = ld; v.req = req; v.en = en; v.bsy = bsy; v.cur = c;
      v.uo = u; v.err = e; v.pe = pe; v.pr = pr;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic add_rep(input int n, input vec_t v);
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   initial begin
      // Slot data: 0x10+i, with slot 0 = 0xA5 and slot 3 = 0x3C; slot 8 is absent.
      for (int i = 0; i < 16; i++) flat[i*8 +: 8] = 8'h10 + 8'(i);
      flat[7:0]   = 8'hA5;
      flat[31:24] = 8'h3C;
      present     = 16'hFEFF;
      for (int i = 0; i < 5; i++) flat5[i*8 +: 8] = 8'h50 + 8'(i);
      present5    = 5'h1F;

      //                 ld   req   en   bsy  cur   uo     err  pena      prst
      add_rep(3, mk(0, 4'd0, 1, 1, 4'd0, 8'h00, 0, 16'h0001, 16'hFFFF)); // power-on settle
      add_rep(1, mk(0, 4'd0, 1, 0, 4'd0, 8'hA5, 0, 16'h0001, 16'hFFFE));
      add_rep(1, mk(1, 4'd3, 1, 1, 4'd0, 8'h00, 0, 16'h0000, 16'hFFFF)); // switch to 3: drain
      add_rep(4, mk(0, 4'd0, 1, 1, 4'd3, 8'h00, 0, 16'h0008, 16'hFFFF));
      add_rep(1, mk(0, 4'd0, 1, 0, 4'd3, 8'h3C, 0, 16'h0008, 16'hFFF7));
      add_rep(1, mk(1, 4'd8, 1, 0, 4'd3, 8'h3C, 1, 16'h0008, 16'hFFF7)); // absent slot rejected
      add_rep(1, mk(0, 4'd0, 1, 0, 4'd3, 8'h3C, 0, 16'h0008, 16'hFFF7));
      add_rep(1, mk(1, 4'd3, 1, 0, 4'd3, 8'h3C, 0, 16'h0008, 16'hFFF7)); // same slot: no-op
      add_rep(1, mk(0, 4'd0, 1, 0, 4'd3, 8'h3C, 0, 16'h0008, 16'hFFF7));
      add_rep(1, mk(1, 4'd1, 1, 1, 4'd3, 8'h00, 0, 16'h0000, 16'hFFFF)); // switch to 1
      add_rep(1, mk(1, 4'd7, 1, 1, 4'd1, 8'h00, 0, 16'h0002, 16'hFFFF)); // pend 7
      add_rep(1, mk(1, 4'd9, 1, 1, 4'd1, 8'h00, 0, 16'h0002, 16'hFFFF)); // pend 9 wins
      add_rep(2, mk(0, 4'd0, 1, 1, 4'd1, 8'h00, 0, 16'h0002, 16'hFFFF));
      add_rep(1, mk(0, 4'd0, 1, 1, 4'd1, 8'h00, 0, 16'h0000, 16'hFFFF)); // second drain
      add_rep(4, mk(0, 4'd0, 1, 1, 4'd9, 8'h00, 0, 16'h0200, 16'hFFFF));
      add_rep(1, mk(0, 4'd0, 1, 0, 4'd9, 8'h19, 0, 16'h0200, 16'hFDFF));
      add_rep(1, mk(0, 4'd0, 0, 0, 4'd9, 8'h00, 0, 16'h0000, 16'hFFFF)); // ena low: OFF
      add_rep(1, mk(1, 4'd3, 0, 0, 4'd9, 8'h00, 0, 16'h0000, 16'hFFFF)); // load 3 while off
      add_rep(4, mk(0, 4'd0, 1, 1, 4'd3, 8'h00, 0, 16'h0008, 16'hFFFF));
      add_rep(1, mk(0, 4'd0, 1, 0, 4'd3, 8'h3C, 0, 16'h0008, 16'hFFF7));
      add_rep(1, mk(1, 4'd0, 1, 1, 4'd3, 8'h00, 0, 16'h0000, 16'hFFFF)); // switch to 0
      add_rep(4, mk(0, 4'd0, 1, 1, 4'd0, 8'h00, 0, 16'h0001, 16'hFFFF));
      add_rep(1, mk(1, 4'd5, 1, 1, 4'd0, 8'h00, 0, 16'h0000, 16'hFFFF)); // load at sequence end
      add_rep(4, mk(0, 4'd0, 1, 1, 4'd5, 8'h00, 0, 16'h0020, 16'hFFFF));
      add_rep(1, mk(0, 4'd0, 1, 0, 4'd5, 8'h15, 0, 16'h0020, 16'hFFDF));
      add_rep(1, mk(1, 4'd2, 1, 1, 4'd5, 8'h00, 0, 16'h0000, 16'hFFFF)); // switch to 2
      add_rep(1, mk(1, 4'd2, 1, 1, 4'd2, 8'h00, 0, 16'h0004, 16'hFFFF)); // pend == target
      add_rep(1, mk(1, 4'd8, 1, 1, 4'd2, 8'h00, 1, 16'h0004, 16'hFFFF)); // reject while busy
      add_rep(2, mk(0, 4'd0, 1, 1, 4'd2, 8'h00, 0, 16'h0004, 16'hFFFF));
      add_rep(1, mk(0, 4'd0, 1, 0, 4'd2, 8'h12, 0, 16'h0004, 16'hFFFB));

      rst = 1'b1; ena = 1'b1; sel_load = 1'b0; sel_req = '0; ld5 = 1'b0; req5 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 0, 32'(busy), 32'd1);
      chk("rst_cur",  0, 32'(cur),  32'd0);
      chk("rst_uo",   0, 32'(uo),   32'd0);
      chk("rst_err",  0, 32'(err),  32'd0);
      chk("rst_pena", 0, 32'(pena), 32'h0000);
      chk("rst_prst", 0, 32'(prst), 32'hFFFF);
      rst = 1'b0;

      for (int k = 0; k < vecs.size(); k++) begin
         sel_load = vecs[k].ld;
         sel_req  = vecs[k].req;
         ena      = vecs[k].en;
         @(posedge clk);
         #1;
         chk("busy", k + 1, 32'(busy), 32'(vecs[k].bsy));
         chk("cur",  k + 1, 32'(cur),  32'(vecs[k].cur));
         chk("uo",   k + 1, 32'(uo),   32'(vecs[k].uo));
         chk("err",  k + 1, 32'(err),  32'(vecs[k].err));
         chk("pena", k + 1, 32'(pena), 32'(vecs[k].pe));
         chk("prst", k + 1, 32'(prst), 32'(vecs[k].pr));
      end
      sel_load = 1'b0;

      // Async reset in the middle of the settle toward slot 3.
      sel_load = 1'b1; sel_req = 4'd3;
      @(posedge clk); #1;
      sel_load = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_pre_cur", 0, 32'(cur), 32'd3);
      rst = 1'b1;
      #1;
      chk("mid_busy", 0, 32'(busy), 32'd1);
      chk("mid_cur",  0, 32'(cur),  32'd0);
      chk("mid_uo",   0, 32'(uo),   32'd0);
      chk("mid_pena", 0, 32'(pena), 32'h0000);
      chk("mid_prst", 0, 32'(prst), 32'hFFFF);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         if (c < 4) begin
            chk("por_busy", c, 32'(busy), 32'd1);
            chk("por_pena", c, 32'(pena), 32'h0001);
         end else begin
            chk("por_busy", c, 32'(busy), 32'd0);
            chk("por_uo",   c, 32'(uo),   32'hA5);
            chk("por_prst", c, 32'(prst), 32'hFFFE);
         end
      end

      // Five-slot instance: indices 5 and 7 are out of range.
      chk("n5_cur0", 0, 32'(cur5), 32'd0);
      chk("n5_uo0",  0, 32'(uo5),  32'h50);
      for (int j = 0; j < 2; j++) begin
         ld5 = 1'b1; req5 = (j == 0) ? 3'd5 : 3'd7;
         @(posedge clk); #1;
         ld5 = 1'b0;
         chk("n5_err",  j, 32'(err5),  32'd1);
         chk("n5_cur",  j, 32'(cur5),  32'd0);
         chk("n5_busy", j, 32'(busy5), 32'd0);
         chk("n5_uo",   j, 32'(uo5),   32'h50);
         @(posedge clk); #1;
         chk("n5_err_clr", j, 32'(err5), 32'd0);
      end
      ld5 = 1'b1; req5 = 3'd4;
      @(posedge clk); #1;
      ld5 = 1'b0;
      chk("n5_drain", 0, 32'(busy5), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("n5_busy4", 0, 32'(busy5), 32'd0);
      chk("n5_cur4",  0, 32'(cur5),  32'd4);
      chk("n5_uo4",   0, 32'(uo5),   32'h54);
      chk("n5_pena4", 0, 32'(pena5), 32'h10);
      chk("n5_prst4", 0, 32'(prst5), 32'h0F);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
